custom_timer_array: RTL

- Memory-mapped peripheral on the core's custom-component bus. It provides NUM_CH independent down-counting timers.
- Each timer has its own reload value, prescaler, one-shot or auto-reload mode, and a sticky done flag.
- Done flags are gathered into one write-1-to-clear status register and an optional interrupt line.
- Same bus protocol as the other custom components: single-cycle synchronous write, combinational read.

---
 rtl/custom_timer_array.sv | 102 ++++++++++
 1 files changed

// File: rtl/custom_timer_array.sv
// custom_timer_array: NUM_CH prescaled down-count timers with W1C status; define CUSTOM_TIMER_IRQ_EN for the IE bits and irq_o.
module custom_timer_array #(
  parameter int NUM_CH      = 4,
  parameter int TIMER_BITS  = 30,
  parameter int SCALER_BITS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        addr_i,
  input  logic              write_en_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] done_o,
  output logic              irq_o
);
`ifdef CUSTOM_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic [3:0]        ch;
  logic [3:0]        off;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] status_q;
  logic [31:0]       chan_rd [NUM_CH];
  logic              unused_bits;
  assign ch          = addr_i[7:4];
  assign off         = addr_i[3:0];
  assign unused_bits = ^data_i;
  assign done_o      = status_q;
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      logic [TIMER_BITS-1:0]  load_q;
      logic [TIMER_BITS-1:0]  count_q;
      logic [SCALER_BITS-1:0] ps_q;
      logic [SCALER_BITS-1:0] pc_q;
      logic                   en_q;
      logic                   auto_q;
      logic                   ie_q;
      logic                   wr;
      logic                   tick;
      assign wr        = write_en_i && ch == 4'(c);
      assign tick      = en_q && pc_q == ps_q;
      assign expire[c] = tick && count_q == '0;
      assign ie[c]     = ie_q;
      assign chan_rd[c] = off == 4'h0 ? 32'(load_q) :
                          off == 4'h4 ? 32'(ps_q) :
                          off == 4'h8 ? {29'b0, ie_q, auto_q, en_q} :
                          off == 4'hC ? 32'(count_q) : 32'b0;
      // Register writes come last so a CTRL write overrides a same-cycle one-shot stop.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          load_q  <= '0;
          count_q <= '0;
          ps_q    <= '0;
          pc_q    <= '0;
          en_q    <= 1'b0;
          auto_q  <= 1'b0;
          ie_q    <= 1'b0;
        end else begin
          if (en_q) pc_q <= tick ? '0 : pc_q + 1'b1;
          if (tick) count_q <= count_q != '0 ? count_q - 1'b1 : auto_q ? load_q : count_q;
          if (expire[c] && !auto_q) en_q <= 1'b0;
          if (wr && off == 4'h0) load_q <= data_i[TIMER_BITS-1:0];
          if (wr && off == 4'h4) ps_q <= data_i[SCALER_BITS-1:0];
          if (wr && off == 4'h8) begin
            en_q   <= data_i[0];
            auto_q <= data_i[1];
            ie_q   <= IRQ_EN & data_i[2];
            if (data_i[0] && !en_q) begin
              count_q <= load_q;
              pc_q    <= '0;
            end
          end
        end
      end
    end
  endgenerate
  // A hardware set in the same cycle as a W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else status_q <= (status_q & ~((write_en_i && addr_i == 8'hF0) ? data_i[NUM_CH-1:0] : '0)) | expire;
  end
`ifdef CUSTOM_TIMER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else irq_q <= |(status_q & ie);
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_CH; i++) if (ch == 4'(i)) data_o = chan_rd[i];
    if (addr_i == 8'hF0) data_o = 32'(status_q);
    if (addr_i == 8'hF4) data_o = 32'(status_q & ie);
  end
endmodule
